// File: rtl/vga_capture.sv
// vga_capture: recovers logical pixel writes from a VGA pin bundle by
// undoing letterbox placement and BLOCK-times upscaling.
//
// Ports:
//   CLOCK_50, reset_n          system clock, async active-low reset
//   VGA_CLK/HS/VS/BLANK_N/R/G/B pin bundle, sampled as data on CLOCK_50
//   wr_en, wr_x, wr_y, wr_r/g/b one write strobe per logical pixel
//   frame_done                 pulse after a frame ending at the last pixel
//   locked                     high while capturing
//   geom_err                   sticky raster geometry error
// Optional: `define VGA_CAPTURE_CHECK_EN enables line/frame length checks.
module vga_capture #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       VGA_CLK,
    input  logic       VGA_HS,
    input  logic       VGA_VS,
    input  logic       VGA_BLANK_N,
    input  logic [7:0] VGA_R,
    input  logic [7:0] VGA_G,
    input  logic [7:0] VGA_B,
    output logic       wr_en,
    output logic [9:0] wr_x,
    output logic [8:0] wr_y,
    output logic [7:0] wr_r,
    output logic [7:0] wr_g,
    output logic [7:0] wr_b,
    output logic       frame_done,
    output logic       locked,
    output logic       geom_err
);
    localparam int BX      = 640 / WIDTH;
    localparam int BY      = 480 / HEIGHT;
    localparam int BLOCK   = (BX < BY) ? BX : BY;
    localparam int X_START = (640 - WIDTH * BLOCK) / 2;
    localparam int Y_START = (480 - HEIGHT * BLOCK) / 2;

    localparam logic [9:0] XS      = 10'(X_START);
    localparam logic [9:0] XW      = 10'(WIDTH * BLOCK);
    localparam logic [8:0] YS      = 9'(Y_START);
    localparam logic [8:0] YW      = 9'(HEIGHT * BLOCK);
    localparam logic [9:0] BLK_MAX = 10'(BLOCK - 1);
    localparam logic [9:0] X_LAST  = 10'(WIDTH - 1);
    localparam logic [8:0] Y_LAST  = 9'(HEIGHT - 1);

    typedef enum logic [1:0] {SEARCH, ALIGN, CAPTURE} state_t;

    logic [27:0] pin_s1, pin_s2;
    logic        clk_s3;
    logic        pclk, hs, vs, blank;
    logic [7:0]  r, g, b;
    logic        unused_hs;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            pin_s1 <= '0;
            pin_s2 <= '0;
            clk_s3 <= 1'b0;
        end else begin
            pin_s1 <= {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
                       VGA_R, VGA_G, VGA_B};
            pin_s2 <= pin_s1;
            clk_s3 <= pin_s2[27];
        end
    end

    assign {pclk, hs, vs, blank, r, g, b} = pin_s2;
    assign unused_hs = hs;

    state_t     st, st_nx;
    logic       blank_q, vs_q;
    logic [9:0] xt, xd, lx;
    logic [8:0] yt, ly;
    logic [9:0] yd;
    logic       last_hit;

    logic       pix, line_end, line_start, frame_start;
    logic       align_go, cap, x_in, y_in, wr_go, fd_go, geom_fail;
    logic [8:0] cur_y, yo;
    logic [9:0] xo;

    // Pixel event: falling edge of the synchronised pixel clock.
    assign pix         = clk_s3 & ~pclk;
    assign line_end    = pix & blank_q & ~blank;
    assign line_start  = pix & ~blank_q & blank;
    assign frame_start = pix & vs_q & ~vs;

    always_comb begin
        st_nx    = st;
        align_go = 1'b0;
        unique case (st)
            SEARCH:  if (frame_start) st_nx = ALIGN;
            ALIGN: begin
                if (line_start) begin
                    st_nx    = CAPTURE;
                    align_go = 1'b1;
                end
            end
            CAPTURE: if (geom_fail) st_nx = SEARCH;
            default: st_nx = SEARCH;
        endcase
    end

    // The ALIGN exit pixel is the first pixel of line 0.
    assign cur_y = align_go ? 9'd0 : yt;
    // Unsigned offsets wrap above the window size when left of/above it.
    assign xo    = xt - XS;
    assign yo    = cur_y - YS;
    assign x_in  = xo < XW;
    assign y_in  = yo < YW;
    assign cap   = pix & ((st == CAPTURE) | align_go);
    assign wr_go = cap & blank & x_in & y_in
                 & (xd == 10'd0) & (yd == 10'd0);

`ifdef VGA_CAPTURE_CHECK_EN
    logic [8:0] lines;
    // A line ending in the same event counts before the frame check.
    assign lines     = yt + {8'd0, line_end};
    assign geom_fail = (st == CAPTURE)
                     & ((line_end & (xt != 10'd640))
                      | (frame_start & (lines != 9'd480)));
`else
    assign geom_fail = 1'b0;
`endif

    assign fd_go = frame_start & (st == CAPTURE) & last_hit
                 & ~geom_fail & ~wr_go;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            st       <= SEARCH;
            blank_q  <= 1'b0;
            vs_q     <= 1'b0;
            xt       <= '0;
            xd       <= '0;
            lx       <= '0;
            yt       <= '0;
            yd       <= '0;
            ly       <= '0;
            last_hit <= 1'b0;
        end else begin
            st <= st_nx;
            if (pix) begin
                blank_q <= blank;
                vs_q    <= vs;
                xt      <= blank ? xt + 10'd1 : 10'd0;
                if (!blank) begin
                    xd <= '0;
                    lx <= '0;
                end else if (x_in) begin
                    if (xd == BLK_MAX) begin
                        xd <= '0;
                        lx <= lx + 10'd1;
                    end else begin
                        xd <= xd + 10'd1;
                    end
                end
                // Frame start wins over a line end in the same event.
                if (frame_start | align_go) begin
                    yt <= '0;
                    yd <= '0;
                    ly <= '0;
                end else if (line_end) begin
                    yt <= yt + 9'd1;
                    if (y_in) begin
                        if (yd == BLK_MAX) begin
                            yd <= '0;
                            ly <= ly + 9'd1;
                        end else begin
                            yd <= yd + 10'd1;
                        end
                    end
                end
                if (wr_go)
                    last_hit <= (lx == X_LAST) & (ly == Y_LAST);
                else if (frame_start | align_go)
                    last_hit <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_en      <= 1'b0;
            wr_x       <= '0;
            wr_y       <= '0;
            wr_r       <= '0;
            wr_g       <= '0;
            wr_b       <= '0;
            frame_done <= 1'b0;
            locked     <= 1'b0;
            geom_err   <= 1'b0;
        end else begin
            wr_en      <= wr_go;
            frame_done <= fd_go;
            locked     <= (st == CAPTURE);
            if (wr_go) begin
                wr_x <= lx;
                wr_y <= ly;
                wr_r <= r;
                wr_g <= g;
                wr_b <= b;
            end
            if (geom_fail)
                geom_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture at 320x200 (BLOCK 2, Y_START 40).
// Short lines keep frames cheap when the geometry check is off.
module tb_vga_capture;
    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       wr_en, frame_done, locked, geom_err;
    logic [9:0] wr_x;
    logic [8:0] wr_y;
    logic [7:0] wr_r, wr_g, wr_b;

    always #5 CLOCK_50 = ~CLOCK_50;

    vga_capture #(.WIDTH(320), .HEIGHT(200)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .VGA_CLK    (VGA_CLK),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_r       (wr_r),
        .wr_g       (wr_g),
        .wr_b       (wr_b),
        .frame_done (frame_done),
        .locked     (locked),
        .geom_err   (geom_err)
    );

    int checks   = 0;
    int failures = 0;
    int wcount   = 0;
    int fdcount  = 0;
    int overlap  = 0;
    logic [9:0] first_x, sec_x, last_x;
    logic [8:0] first_y, last_y;
    logic [7:0] first_r, first_g, sec_r, last_r, last_g, last_b;

    always @(negedge CLOCK_50) begin
        if (wr_en) begin
            if (wcount == 0) begin
                first_x = wr_x;
                first_y = wr_y;
                first_r = wr_r;
                first_g = wr_g;
            end
            if (wcount == 1) begin
                sec_x = wr_x;
                sec_r = wr_r;
            end
            wcount++;
            last_x = wr_x;
            last_y = wr_y;
            last_r = wr_r;
            last_g = wr_g;
            last_b = wr_b;
        end
        if (frame_done) fdcount++;
        if (wr_en && frame_done) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pin pixel: data and VGA_CLK high for 2 cycles, then low for 2.
    task automatic pix(input logic bl, input logic v,
                       input int x, input int y);
        VGA_BLANK_N = bl;
        VGA_HS      = bl;
        VGA_VS      = v;
        VGA_R       = bl ? 8'(x) : 8'h00;
        VGA_G       = bl ? 8'(y) : 8'h00;
        VGA_B       = bl ? ~8'(x) : 8'h00;
        VGA_CLK     = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        VGA_CLK     = 1'b0;
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic line(input int y, input int n);
        for (int x = 0; x < n; x++) pix(1'b1, 1'b1, x, y);
        pix(1'b0, 1'b1, 0, y);
        pix(1'b0, 1'b1, 0, y);
    endtask

    task automatic vsync();
        pix(1'b0, 1'b0, 0, 0);
        pix(1'b0, 1'b0, 0, 0);
        pix(1'b0, 1'b1, 0, 0);
        pix(1'b0, 1'b1, 0, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        VGA_CLK     = 1'b0;
        VGA_HS      = 1'b1;
        VGA_VS      = 1'b1;
        VGA_BLANK_N = 1'b0;
        VGA_R       = 8'h00;
        VGA_G       = 8'h00;
        VGA_B       = 8'h00;
        repeat (3) @(negedge CLOCK_50);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_x", wr_x, 0);
        chk("rst_wr_y", wr_y, 0);
        chk("rst_wr_r", wr_r, 0);
        chk("rst_wr_g", wr_g, 0);
        chk("rst_wr_b", wr_b, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_locked", locked, 0);
        chk("rst_geom_err", geom_err, 0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;

`ifdef VGA_CAPTURE_CHECK_EN
        vsync();
        line(0, 640);
        #1;
        chk("chk_locked", locked, 1);
        chk("chk_no_err", geom_err, 0);
        line(1, 639);
        #1;
        chk("short_geom_err", geom_err, 1);
        chk("short_unlocked", locked, 0);
        line(2, 640);
        #1;
        chk("search_after_err", locked, 0);
        chk("err_sticky", geom_err, 1);
        chk("err_no_wr", wcount, 0);
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        #1;
        chk("err_reset", geom_err, 0);
`else
        // Start mid-frame: nothing until a VS falling edge.
        for (int y = 300; y < 303; y++) line(y, 20);
        #1;
        chk("search_no_wr", wcount, 0);
        chk("search_unlocked", locked, 0);
        vsync();
        #1;
        chk("align_unlocked", locked, 0);
        line(0, 8);
        #1;
        chk("locked_line0", locked, 1);
        for (int y = 1; y < 40; y++) line(y, 8);
        #1;
        chk("no_wr_top_band", wcount, 0);

        // Line 40: first logical row; check write latency.
        pix(1'b1, 1'b1, 0, 40);
        chk("lat_pre", wr_en, 0);
        @(negedge CLOCK_50);
        chk("lat_hit", wr_en, 1);
        @(negedge CLOCK_50);
        chk("lat_one_cycle", wr_en, 0);
        for (int x = 1; x < 640; x++) pix(1'b1, 1'b1, x, 40);
        pix(1'b0, 1'b1, 0, 40);
        pix(1'b0, 1'b1, 0, 40);
        #1;
        chk("l40_count", wcount, 320);
        chk("first_x", first_x, 0);
        chk("first_y", first_y, 0);
        chk("first_r", first_r, 0);
        chk("first_g", first_g, 40);
        chk("second_x", sec_x, 1);
        chk("second_r", sec_r, 2);
        chk("l40_last_x", last_x, 319);
        chk("l40_last_r", last_r, 8'h7E);
        chk("l40_last_b", last_b, 8'h81);

        line(41, 8);
        line(42, 6);
        #1;
        chk("l42_count", wcount, 323);
        chk("l42_last_x", last_x, 2);
        chk("l42_last_y", last_y, 1);
        chk("l42_last_r", last_r, 4);
        chk("l42_last_g", last_g, 42);

        for (int y = 43; y < 438; y++) line(y, 2);
        line(438, 640);
        #1;
        chk("last_px_x", last_x, 319);
        chk("last_px_y", last_y, 199);
        chk("last_px_g", last_g, 8'hB6);
        line(439, 8);
        for (int y = 440; y < 480; y++) line(y, 8);
        #1;
        chk("frame_writes", wcount, 840);
        chk("no_early_done", fdcount, 0);
        vsync();
        #1;
        chk("frame_done", fdcount, 1);
        chk("locked_kept", locked, 1);

        // Second frame restarts at logical (0,0) on pin line 40.
        for (int y = 0; y < 40; y++) line(y, 8);
        line(40, 4);
        #1;
        chk("f2_count", wcount, 842);
        chk("f2_last_x", last_x, 1);
        chk("f2_last_y", last_y, 0);
        chk("f2_last_r", last_r, 2);

        // Reset in the middle of a line.
        pix(1'b1, 1'b1, 0, 41);
        pix(1'b1, 1'b1, 1, 41);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_wr_x", wr_x, 0);
        chk("mid_rst_wr_y", wr_y, 0);
        chk("mid_rst_wr_r", wr_r, 0);
        chk("mid_rst_wr_g", wr_g, 0);
        chk("mid_rst_wr_b", wr_b, 0);
        chk("mid_rst_locked", locked, 0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        for (int x = 2; x < 100; x++) pix(1'b1, 1'b1, x, 41);
        pix(1'b0, 1'b1, 0, 41);
        for (int y = 42; y < 46; y++) line(y, 20);
        #1;
        chk("post_rst_no_wr", wcount, 842);
        chk("post_rst_unlocked", locked, 0);
        vsync();
        #1;
        chk("post_rst_align", locked, 0);
        line(0, 8);
        line(1, 8);
        #1;
        chk("post_rst_locked", locked, 1);
        vsync();
        #1;
        chk("no_partial_done", fdcount, 1);
        chk("no_overlap", overlap, 0);
        chk("geom_err_off", geom_err, 0);
        chk("final_count", wcount, 842);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
